// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit control blocks.
//   state_t     : 2-bit FSM encoding used by the transmit arbiter
//   UART_DATA_W : byte width accepted by uart_send
//   TIMEOUT_DEF : default number of cycles to wait for uart_send busy to rise
package uart_ctrl_pkg;

  localparam int UART_DATA_W = 8;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority select.
//   req  in  N      : request vector
//   last in  log2 N : index granted last time; the search starts at last+1
//   pick out log2 N : first set request at or after last+1, wrapping modulo N
//   any  out 1      : at least one request is set (pick is valid)
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] pick,
  output logic          any
);

  // Walk from the farthest candidate (last+N, i.e. last itself) down to the
  // nearest (last+1) so the nearest set request overwrites earlier hits.
  always_comb begin
    pick = last;
    any  = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        pick = IW'((int'(last) + k) % N);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_send transmitter among N_REQ requesters.
//   clk, rst     : bit-rate clock, asynchronous active-high reset
//   req_valid    : per-requester byte pending, held until its req_ack
//   req_data     : flattened bytes, requester i at [i*DATA_W +: DATA_W]
//   req_last     : byte ends the packet; 0 keeps the grant locked
//   req_ack      : one-cycle pulse, byte of the granted requester captured
//   tx_trig      : one-cycle start pulse to uart_send
//   tx_data      : captured byte, stable for the whole frame
//   tx_busy      : uart_send busy flag
//   grant        : current or last granted requester
//   locked       : grant held for a multi-byte packet
//   timeout_err  : one-cycle pulse when tx_busy never rose after a launch
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int DATA_W  = UART_DATA_W,
  parameter  int TIMEOUT = TIMEOUT_DEF,
  localparam int GW      = $clog2(N_REQ),
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ack,
  output logic                    tx_trig,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic [GW-1:0]           grant,
  output logic                    locked,
  output logic                    timeout_err
);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [GW-1:0]   pick, sel;
  logic            any, sel_ok;

  rr_pick #(.N(N_REQ)) u_pick (
    .req  (req_valid),
    .last (grant),
    .pick (pick),
    .any  (any)
  );

  // While a packet is in flight only the owner may continue it.
  assign sel    = locked ? grant : pick;
  assign sel_ok = locked ? req_valid[grant] : any;

  wire timed_out = !tx_busy && (cnt == CW'(TIMEOUT - 1));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (sel_ok) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_BUSY;
      // A busy flag left over from a frame started before a reset is
      // accepted here too; the FSM then simply rides that frame out.
      WAIT_BUSY: if (tx_busy) state_nxt = WAIT_DONE;
                 else if (timed_out) state_nxt = IDLE;
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // outputs decoded from registered state only
  always_comb begin
    tx_trig = (state == LAUNCH);
    req_ack = tx_trig ? (N_REQ'(1) << grant) : '0;
  end

  // capture, lock and timeout bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant       <= GW'(N_REQ - 1);
      locked      <= 1'b0;
      tx_data     <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (sel_ok) begin
          grant   <= sel;
          tx_data <= req_data[int'(sel)*DATA_W +: DATA_W];
          locked  <= ~req_last[sel];
        end
        LAUNCH: cnt <= '0;
        WAIT_BUSY: if (!tx_busy) begin
          if (timed_out) begin
            // byte is dropped; releasing the lock lets others proceed
            timeout_err <= 1'b1;
            locked      <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 15;
  localparam int FR = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ack;
  logic [N*8-1:0] req_data;
  logic           tx_trig, tx_busy, locked, timeout_err;
  logic [7:0]     tx_data;
  logic [1:0]     grant;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ack(req_ack), .tx_trig(tx_trig), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant(grant), .locked(locked), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin @(posedge clk); cyc++; end

  // ---------------- behavioural reference ----------------
  // m_since: -1 arbiter free; 0 launch cycle; k>0 k-th cycle waiting for busy.
  int         m_since;
  bit         m_frame;
  logic [1:0] m_g;
  bit         m_lock;
  logic [7:0] m_data;
  bit         e_trig, e_err;
  int         mc;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_since = -1; m_frame = 0; m_g = 2'(N-1); m_lock = 0; m_data = 0;
      e_trig = 0; e_err = 0;
    end else begin
      e_trig = 0; e_err = 0;
      if (m_since < 0) begin
        mc = -1;
        if (m_lock) begin
          if (req_valid[m_g]) mc = int'(m_g);
        end else begin
          for (int k = 1; k <= N; k++)
            if (mc < 0 && req_valid[(int'(m_g) + k) % N]) mc = (int'(m_g) + k) % N;
        end
        if (mc >= 0) begin
          m_g = mc[1:0]; m_data = req_data[mc*8 +: 8]; m_lock = !req_last[mc];
          e_trig = 1; m_since = 0; m_frame = 0;
        end
      end else if (m_since == 0) m_since = 1;
      else if (!m_frame) begin
        if (tx_busy) m_frame = 1;
        else if (m_since == TO) begin e_err = 1; m_lock = 0; m_since = -1; end
        else m_since++;
      end else if (!tx_busy) m_since = -1;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [1:0] log_g[$];
  bit         log_l[$];
  int         trig_cyc[$], err_cyc[$];

  initial forever begin
    @(negedge clk);
    chk("tx_trig", 32'(tx_trig), 32'(e_trig));
    chk("req_ack", 32'(req_ack), e_trig ? (32'd1 << m_g) : 32'd0);
    chk("grant", 32'(grant), 32'(m_g));
    chk("locked", 32'(locked), 32'(m_lock));
    chk("tx_data", 32'(tx_data), 32'(m_data));
    chk("timeout_err", 32'(timeout_err), 32'(e_err));
    if (tx_trig) begin log_g.push_back(grant); log_l.push_back(locked); trig_cyc.push_back(cyc); end
    if (timeout_err) err_cyc.push_back(cyc);
  end

  // ---------------- requesters ----------------
  logic [8:0] qb [N][64];
  int         qh [N], qt [N];
  bit         gaps;
  logic [N-1:0] ack_s;

  task automatic push(int i, logic last, logic [7:0] d);
    qb[i][qt[i] % 64] = {last, d};
    qt[i]++;
  endtask

  initial begin
    req_valid = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin qh[i] = 0; qt[i] = 0; end
    forever begin
      @(negedge clk); ack_s = req_ack;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (ack_s[i] && req_valid[i]) begin qh[i]++; req_valid[i] = 1'b0; end
        if (!req_valid[i] && qh[i] != qt[i] && (!gaps || $urandom_range(0, 2) != 0)) begin
          req_valid[i]      = 1'b1;
          req_data[i*8 +: 8] = qb[i][qh[i] % 64][7:0];
          req_last[i]       = qb[i][qh[i] % 64][8];
        end
      end
    end
  end

  // ---------------- uart_send stand-in ----------------
  bit         tie0, drop_en, frame_void, trig_s;
  int         ubit;
  logic [9:0] rx, rx_last;
  logic [7:0] fbyte;

  task automatic emit();
    rx[ubit] = (ubit == 0) ? 1'b0 : (ubit == FR-1) ? 1'b1 : tx_data[ubit-1];
    ubit++;
  endtask

  initial begin
    tx_busy = 1'b0; ubit = 0; rx = '0; rx_last = '0;
    forever begin
      @(negedge clk); trig_s = tx_trig;
      @(posedge clk); #1;
      if (tx_busy) begin
        if (ubit == FR) begin
          tx_busy = 1'b0; rx_last = rx;
          if (!frame_void) chk("frame", 32'(rx), 32'({1'b1, fbyte, 1'b0}));
        end else emit();
      end else if (trig_s && !tie0 && !(drop_en && $urandom_range(0, 5) == 0)) begin
        tx_busy = 1'b1; fbyte = m_data; frame_void = 0; ubit = 0; emit();
      end
    end
  end

  // ---------------- sequencing helpers ----------------
  function automatic bit quiet();
    bit q = (req_valid == '0) && !tx_busy && (m_since < 0);
    for (int i = 0; i < N; i++) if (qh[i] != qt[i]) q = 0;
    return q;
  endfunction

  task automatic drain(int lim);
    int n = 0;
    while (!quiet() && n < lim) begin @(posedge clk); #2; n++; end
    chk("drain_bound", 32'(n < lim), 32'd1);
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #3 rst = 1'b0;
    log_g.delete(); log_l.delete(); trig_cyc.delete(); err_cyc.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  int n;

  initial begin
    rst = 1'b1; tie0 = 0; drop_en = 0; gaps = 0; frame_void = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_grant", 32'(grant), 32'd3);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_trig_ack", 32'({tx_trig, req_ack, timeout_err}), 32'd0);
    rst = 1'b0;

    // single request
    @(negedge clk); push(0, 1'b1, 8'h55);
    drain(200);
    chk("single_count", 32'(log_g.size()), 32'd1);
    chk("single_grant", 32'(log_g[0]), 32'd0);
    chk("single_data", 32'(tx_data), 32'h55);
    chk("single_frame", 32'(rx_last), 32'h2AA);

    // fairness
    do_reset();
    @(negedge clk);
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push(i, 1'b1, 8'(16*i + r));
    drain(1000);
    chk("fair_count", 32'(log_g.size()), 32'd8);
    for (int j = 0; j < 5; j++) chk("fair_order", 32'(log_g[j]), 32'(j % N));

    // lock: requester 2 sends 3 bytes, requester 1 joins after the first
    do_reset();
    @(negedge clk);
    push(2, 1'b0, 8'hA1); push(2, 1'b0, 8'hA2); push(2, 1'b1, 8'hA3);
    n = 0;
    while (log_g.size() == 0 && n < 100) begin @(negedge clk); n++; end
    chk("lock_start_bound", 32'(n < 100), 32'd1);
    push(1, 1'b1, 8'hB1);
    drain(1000);
    chk("lock_count", 32'(log_g.size()), 32'd4);
    chk("lock_g0", 32'(log_g[0]), 32'd2); chk("lock_g1", 32'(log_g[1]), 32'd2);
    chk("lock_g2", 32'(log_g[2]), 32'd2); chk("lock_g3", 32'(log_g[3]), 32'd1);
    chk("lock_l0", 32'(log_l[0]), 32'd1); chk("lock_l1", 32'(log_l[1]), 32'd1);
    chk("lock_l2", 32'(log_l[2]), 32'd0);

    // timeout: busy never rises
    do_reset();
    tie0 = 1;
    @(negedge clk); push(3, 1'b0, 8'hC3);
    drain(200);
    @(negedge clk); push(1, 1'b1, 8'h11);
    drain(200);
    chk("to_errs", 32'(err_cyc.size()), 32'd2);
    chk("to_grants", 32'({log_g[0], log_g[1]}), 32'({2'd3, 2'd1}));
    chk("to_delay", 32'(err_cyc[0] - trig_cyc[0]), 32'(TO + 1));
    chk("to_unlocked", 32'(locked), 32'd0);
    tie0 = 0;

    // reset in the middle of a frame
    do_reset();
    @(negedge clk); push(0, 1'b1, 8'hA5);
    n = 0;
    while (!(tx_busy && m_frame && ubit > 2) && n < 100) begin @(negedge clk); n++; end
    chk("midrst_frame_bound", 32'(n < 100), 32'd1);
    frame_void = 1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_grant", 32'(grant), 32'd3);
    chk("midrst_zero", 32'({tx_trig, req_ack, locked, timeout_err, tx_data}), 32'd0);
    @(posedge clk); #3 rst = 1'b0;
    log_g.delete(); err_cyc.delete();
    push(2, 1'b1, 8'h3C);
    drain(300);
    chk("midrst_granted", 32'(log_g.size()), 32'd1);
    chk("midrst_no_err", 32'(err_cyc.size()), 32'd0);

    // randomized traffic with occasional lost triggers
    do_reset();
    drop_en = 1; gaps = 1;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 25; b++)
        push(i, (b == 24) ? 1'b1 : ($urandom_range(0, 2) != 0), 8'($urandom));
    drain(20000);
    chk("rand_count", 32'(log_g.size()), 32'd100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
